bg_pixel_shifter: RTL and testbench

Background pixel FIFO and shifter sitting directly downstream of the BG tile fetcher in the PPU.
- Accepts one ppu_pixel_t per push from the fetcher.
- Discards SCX[2:0] fine-scroll pixels at the start of each line.
- Pops one pixel per mode-3 dot and maps its colour through BGP.
- Emits an X-tagged 2-bit shade to the LCD/mixer stage and signals end of the visible line.

---
 rtl/bg_pixel_shifter.sv | 146 ++++++++++++++
 tb/tb_bg_pixel_shifter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_pixel_shifter.sv
// Background pixel FIFO + fine-scroll discard + BGP shade mapping for the PPU.
// Optional: define PPU_BG_LCDC0_BLANK_EN to force colour 0 whenever LCDC[0]=0.
package ppu_pkg;
    typedef struct packed {
        logic [7:0] lcdc;
        logic [7:0] scx;
        logic [7:0] bgp;
    } ppu_regs_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] color;
    } ppu_pixel_t;
endpackage

module bg_pixel_shifter
    import ppu_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned LINE_WIDTH = 160
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dot_en,
    input  logic                     line_start,
    input  logic                     flush,
    input  ppu_regs_t                regs,
    input  logic                     push_en,
    input  ppu_pixel_t               push_px,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     pix_valid,
    output logic [7:0]               pix_x,
    output logic [1:0]               pix_shade,
    output logic                     line_done
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, DISCARD, SHIFT, DONE} state_t;

    state_t        state;
    logic [1:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [2:0]    discard_cnt;
    logic [7:0]    x_cnt;

    logic          ops_en_c;
    logic          push_c;
    logic          pop_c;
    logic [1:0]    pop_color_c;
    logic [CW-1:0] count_next_c;
    logic          unused_regs_c;

    // line_start and flush both pre-empt any push or pop in the same cycle
    assign ops_en_c     = !line_start && !flush;
    assign push_c       = ops_en_c && push_en && !fifo_full;
    assign pop_c        = ops_en_c && dot_en && !fifo_empty &&
                          (state == DISCARD || state == SHIFT);
    assign count_next_c = count + CW'(push_c) - CW'(pop_c);
    assign unused_regs_c = ^{regs.scx[7:3], regs.lcdc};

`ifdef PPU_BG_LCDC0_BLANK_EN
    assign pop_color_c = regs.lcdc[0] ? mem[rd_ptr] : 2'd0;
`else
    assign pop_color_c = mem[rd_ptr];
`endif

    // Invalid fetcher pixels are stored as colour 0
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= push_px.valid ? push_px.color : 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fifo_full   <= 1'b0;
            fifo_empty  <= 1'b1;
            overflow    <= 1'b0;
            discard_cnt <= '0;
            x_cnt       <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_shade   <= '0;
            line_done   <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            line_done <= 1'b0;
            if (line_start) begin
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                count       <= '0;
                fifo_full   <= 1'b0;
                fifo_empty  <= 1'b1;
                overflow    <= 1'b0;
                discard_cnt <= regs.scx[2:0];
                x_cnt       <= '0;
                state       <= (regs.scx[2:0] != 3'd0) ? DISCARD : SHIFT;
            end else if (flush) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                count      <= '0;
                fifo_full  <= 1'b0;
                fifo_empty <= 1'b1;
            end else begin
                if (push_en && fifo_full) begin
                    overflow <= 1'b1;
                end
                if (push_c) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                count      <= count_next_c;
                fifo_full  <= (count_next_c == CW'(DEPTH));
                fifo_empty <= (count_next_c == '0);
                if (pop_c) begin
                    rd_ptr <= rd_ptr + PW'(1);
                    if (state == DISCARD) begin
                        discard_cnt <= discard_cnt - 3'd1;
                        if (discard_cnt == 3'd1) begin
                            state <= SHIFT;
                        end
                    end else begin
                        pix_valid <= 1'b1;
                        pix_x     <= x_cnt;
                        pix_shade <= regs.bgp[{pop_color_c, 1'b0} +: 2];
                        // x_cnt parks at the last pixel once the line is done
                        if (x_cnt == 8'(LINE_WIDTH - 1)) begin
                            line_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            x_cnt <= x_cnt + 8'd1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_bg_pixel_shifter.sv
// Directed bench for bg_pixel_shifter: cycle table for the basic pipe plus scripted corner cases.
module tb_bg_pixel_shifter;
    import ppu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       dot_en;
    logic       line_start;
    logic       flush;
    ppu_regs_t  regs;
    logic       push_en;
    ppu_pixel_t push_px;
    logic       fifo_full;
    logic       fifo_empty;
    logic [4:0] count;
    logic       overflow;
    logic       pix_valid;
    logic [7:0] pix_x;
    logic [1:0] pix_shade;
    logic       line_done;

    int n_checks = 0;
    int n_fail   = 0;

    bg_pixel_shifter #(.DEPTH(16), .LINE_WIDTH(160)) dut (
        .clk(clk), .reset(reset), .dot_en(dot_en), .line_start(line_start),
        .flush(flush), .regs(regs), .push_en(push_en), .push_px(push_px),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .count(count),
        .overflow(overflow), .pix_valid(pix_valid), .pix_x(pix_x),
        .pix_shade(pix_shade), .line_done(line_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ls;
        logic       push;
        logic       valid;
        logic [1:0] color;
        logic       dot;
        logic       exp_pv;
        int         exp_x;
        int         exp_shade;
        int         exp_count;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Inputs are set after the sampling point, so they are stable for the next edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dot_en = 1'b0; line_start = 1'b0; flush = 1'b0;
        push_en = 1'b0; push_px = '{valid: 1'b1, color: 2'd0};
    endtask

    task automatic do_line_start(input logic [7:0] scx);
        regs.scx = scx;
        line_start = 1'b1;
        cycle();
        line_start = 1'b0;
    endtask

    int exp_x;
    int seen;
    int exp_shade;

    initial begin
        vecs[0]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 1, 0, 1, 0, 0, 0, 1};
        vecs[2]  = '{0, 1, 1, 1, 1, 1, 0, 0, 1};
        vecs[3]  = '{0, 1, 1, 2, 1, 1, 1, 1, 1};
        vecs[4]  = '{0, 1, 1, 3, 1, 1, 2, 2, 1};
        vecs[5]  = '{0, 1, 1, 0, 1, 1, 3, 3, 1};
        vecs[6]  = '{0, 1, 1, 1, 1, 1, 4, 0, 1};
        vecs[7]  = '{0, 1, 1, 2, 1, 1, 5, 1, 1};
        vecs[8]  = '{0, 1, 1, 3, 1, 1, 6, 2, 1};
        vecs[9]  = '{0, 1, 0, 3, 1, 1, 7, 3, 1};
        vecs[10] = '{0, 0, 1, 0, 1, 1, 8, 0, 0};
        vecs[11] = '{0, 0, 1, 0, 1, 0, 0, 0, 0};

        idle_inputs();
        regs = '{lcdc: 8'h91, scx: 8'h00, bgp: 8'hE4};
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        chk("rst_count", count, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_x", pix_x, 0);
        chk("rst_pix_shade", pix_shade, 0);
        chk("rst_line_done", line_done, 0);

        // Basic pipe, SCX=0, BGP=E4; last pushed pixel is invalid and must map as colour 0
        for (int i = 0; i < 12; i++) begin
            line_start = vecs[i].ls;
            push_en    = vecs[i].push;
            push_px    = '{valid: vecs[i].valid, color: vecs[i].color};
            dot_en     = vecs[i].dot;
            cycle();
            chk($sformatf("t1_pv[%0d]", i), pix_valid, vecs[i].exp_pv);
            chk($sformatf("t1_count[%0d]", i), count, vecs[i].exp_count);
            if (vecs[i].exp_pv) begin
                chk($sformatf("t1_x[%0d]", i), pix_x, vecs[i].exp_x);
                chk($sformatf("t1_shade[%0d]", i), pix_shade, vecs[i].exp_shade);
            end
        end
        idle_inputs();

        // Fine scroll of 5: pixels 0..4 are dropped, pixel 5 shows up as x=0
        do_line_start(8'h05);
        exp_x = 0;
        for (int i = 0; i < 40; i++) begin
            push_en = (i < 16);
            push_px = '{valid: 1'b1, color: 2'(i)};
            dot_en  = 1'b1;
            cycle();
            if (pix_valid) begin
                chk("t2_x", pix_x, exp_x);
                chk("t2_shade", pix_shade, (exp_x + 5) % 4);
                exp_x++;
            end
        end
        chk("t2_emitted", exp_x, 11);
        idle_inputs();

        // Fill to full without popping, then overflow, then clear on line_start
        do_line_start(8'h00);
        push_en = 1'b1;
        repeat (16) cycle();
        chk("t3_count_full", count, 16);
        chk("t3_full", fifo_full, 1);
        chk("t3_no_ovf_yet", overflow, 0);
        cycle();
        chk("t3_overflow", overflow, 1);
        chk("t3_count_held", count, 16);
        line_start = 1'b1;
        cycle();
        line_start = 1'b0;
        push_en = 1'b0;
        chk("t3_ls_overflow", overflow, 0);
        chk("t3_ls_count", count, 0);
        chk("t3_ls_empty", fifo_empty, 1);

        // Full line of 160 pixels, then DONE ignores dots but still accepts pushes
        do_line_start(8'h00);
        exp_x = 0;
        for (int i = 0; i < 400 && exp_x < 160; i++) begin
            push_en = !fifo_full;
            push_px = '{valid: 1'b1, color: 2'd2};
            dot_en  = 1'b1;
            cycle();
            chk("t4_line_done", line_done, int'(pix_valid && pix_x == 8'd159));
            if (pix_valid) begin
                chk("t4_x", pix_x, exp_x);
                exp_x++;
            end
        end
        chk("t4_emitted", exp_x, 160);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            push_en = !fifo_full;
            dot_en  = 1'b1;
            cycle();
            if (pix_valid || line_done) seen++;
        end
        chk("t4_done_silent", seen, 0);
        chk("t4_done_fills", fifo_full, 1);
        idle_inputs();

        // Push+pop at count 4 keeps count; dot gaps stall without losing X
        do_line_start(8'h00);
        push_en = 1'b1;
        repeat (4) cycle();
        chk("t5_count4", count, 4);
        dot_en = 1'b1;
        cycle();
        chk("t5_count_same", count, 4);
        chk("t5_pv0", pix_valid, 1);
        chk("t5_x0", pix_x, 0);
        push_en = 1'b0;
        dot_en = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (pix_valid) seen++;
        end
        chk("t5_stall", seen, 0);
        dot_en = 1'b1;
        cycle();
        chk("t5_resume_pv", pix_valid, 1);
        chk("t5_resume_x", pix_x, 1);
        chk("t5_resume_count", count, 3);
        idle_inputs();

        // Flush at x_cnt=40 with 6 queued; next pixel continues at x=40
        do_line_start(8'h00);
        seen = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            push_en = 1'b1;
            dot_en  = 1'b1;
            cycle();
            if (pix_valid && pix_x == 8'd39) seen = 1;
        end
        chk("t6_reached_39", seen, 1);
        dot_en = 1'b0;
        for (int i = 0; i < 20 && count != 5'd6; i++) cycle();
        chk("t6_count6", count, 6);
        push_en = 1'b1;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        push_en = 1'b0;
        chk("t6_flush_count", count, 0);
        chk("t6_flush_empty", fifo_empty, 1);
        chk("t6_flush_no_ovf", overflow, 0);
        regs.bgp = 8'h1B;
        regs.lcdc = 8'h90;
        push_en = 1'b1;
        push_px = '{valid: 1'b1, color: 2'd2};
        dot_en = 1'b1;
        cycle();
        push_en = 1'b0;
        chk("t6_after_push_pv", pix_valid, 0);
        cycle();
`ifdef PPU_BG_LCDC0_BLANK_EN
        exp_shade = 3;
`else
        exp_shade = 1;
`endif
        chk("t6_pv", pix_valid, 1);
        chk("t6_x40", pix_x, 40);
        chk("t6_shade", pix_shade, exp_shade);
        idle_inputs();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
